// File: rtl/nd_pkg.sv
// rtl/nd_pkg.sv - shared types and elaboration helpers for the nd_tree_pipe reduction tree
package nd_pkg;

  typedef enum logic [2:0] {
    ND_AND  = 3'd0,
    ND_NAND = 3'd1,
    ND_OR   = 3'd2,
    ND_NOR  = 3'd3,
    ND_XOR  = 3'd4
  } nd_mode_t;

  typedef enum logic [1:0] {
    ND_BASE_AND = 2'd0,
    ND_BASE_OR  = 2'd1,
    ND_BASE_XOR = 2'd2
  } nd_base_t;

  // WIDTH=256 with GROUP=2 is the deepest legal tree
  localparam int ND_MAX_STAGES = 8;

  // Number of tree levels: smallest s with group**s >= width
  function automatic int nd_stages(input int width, input int group);
    int s;
    int p;
    s = 0;
    p = 1;
    for (int i = 0; i < ND_MAX_STAGES; i++) begin
      if (p < width) begin
        p = p * group;
        s = s + 1;
      end
    end
    return s;
  endfunction

  function automatic int nd_pow(input int base, input int e);
    int r;
    r = 1;
    for (int i = 0; i < ND_MAX_STAGES; i++) begin
      if (i < e) r = r * base;
    end
    return r;
  endfunction

  // Bit offset of tree level lvl inside the flattened level bus (level 0 = padded leaves)
  function automatic int nd_level_off(input int group, input int stages, input int lvl);
    int off;
    off = 0;
    for (int j = 0; j < ND_MAX_STAGES + 2; j++) begin
      if (j < lvl) off = off + nd_pow(group, stages - j);
    end
    return off;
  endfunction

  // Value that leaves a reduction unchanged; reserved modes behave as AND
  function automatic logic nd_identity(input nd_mode_t mode);
    case (mode)
      ND_OR, ND_NOR, ND_XOR: return 1'b0;
      default:               return 1'b1;
    endcase
  endfunction

  function automatic nd_base_t nd_base_op(input nd_mode_t mode);
    case (mode)
      ND_OR, ND_NOR: return ND_BASE_OR;
      ND_XOR:        return ND_BASE_XOR;
      default:       return ND_BASE_AND;
    endcase
  endfunction

  function automatic logic nd_invert(input nd_mode_t mode);
    case (mode)
      ND_NAND, ND_NOR: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nd_tree_stage.sv
// rtl/nd_tree_stage.sv - one registered level of GROUP-input gates with valid/ready hand-off
module nd_tree_stage
  import nd_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int GROUP = 4,
  parameter bit LAST  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [IN_W-1:0]       data_i,
  input  nd_mode_t              mode_i,
  input  logic                  all_masked_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [IN_W/GROUP-1:0] data_o,
  output nd_mode_t              mode_o,
  output logic                  all_masked_o
);

  localparam int OUT_W = IN_W / GROUP;

  logic             valid_q;
  logic [OUT_W-1:0] data_q;
  logic [OUT_W-1:0] node_d;
  nd_mode_t         mode_q;
  logic             all_masked_q;
  logic [GROUP-1:0] grp;
  logic             advance;

  // A stage moves when it is empty or its successor is moving; this chains back combinationally
  assign advance = ~valid_q | ready_i;
  assign ready_o = advance;

  // Node gates use the base op; the NAND/NOR inversion is folded into the last level only
  always_comb begin
    node_d = '0;
    grp    = '0;
    for (int n = 0; n < OUT_W; n++) begin
      grp = data_i[n*GROUP +: GROUP];
      case (nd_base_op(mode_i))
        ND_BASE_OR:  node_d[n] = |grp;
        ND_BASE_XOR: node_d[n] = ^grp;
        default:     node_d[n] = &grp;
      endcase
      if (LAST && nd_invert(mode_i)) node_d[n] = ~node_d[n];
    end
  end

  // Register the level; payload loads only with a real item so outputs hold between items
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      mode_q       <= ND_AND;
      all_masked_q <= 1'b0;
    end else if (advance) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q       <= node_d;
        mode_q       <= mode_i;
        all_masked_q <= all_masked_i;
      end
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign mode_o       = mode_q;
  assign all_masked_o = all_masked_q;

endmodule

// File: rtl/nd_tree_pipe.sv
// rtl/nd_tree_pipe.sv - pipelined masked AND/NAND/OR/NOR/XOR reduction of a WIDTH-bit vector
module nd_tree_pipe
  import nd_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int GROUP = 4
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             q,
  output logic             all_masked
);

  localparam int STAGES = nd_stages(WIDTH, GROUP);
  localparam int LEAF_W = nd_pow(GROUP, STAGES);
  localparam int TOT_W  = nd_level_off(GROUP, STAGES, STAGES + 1);
  localparam int Q_OFF  = nd_level_off(GROUP, STAGES, STAGES);

  // All tree levels packed end to end: leaves first, final single bit last
  logic [TOT_W-1:0]  lvl_data;
  logic [STAGES:0]   lvl_valid;
  logic [STAGES:0]   lvl_ready;
  logic [STAGES:0]   lvl_am;
  nd_mode_t          lvl_mode [STAGES+1];
  nd_mode_t          mode_in;
  logic              leaf_id;
  logic [LEAF_W-1:0] leaf;

  assign mode_in = nd_mode_t'(in_mode);
  assign leaf_id = nd_identity(mode_in);

  // Masked-out bits and the padding beyond WIDTH take the identity so they never affect the result
  always_comb begin
    leaf = {LEAF_W{leaf_id}};
    for (int b = 0; b < WIDTH; b++) begin
      leaf[b] = in_mask[b] ? in_data[b] : leaf_id;
    end
  end

  assign lvl_data[LEAF_W-1:0] = leaf;
  assign lvl_valid[0]         = in_valid;
  assign lvl_mode[0]          = mode_in;
  assign lvl_am[0]            = ~|in_mask;
  assign lvl_ready[STAGES]    = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int IW = nd_pow(GROUP, STAGES - i);
    localparam int OW = IW / GROUP;
    localparam int IO = nd_level_off(GROUP, STAGES, i);
    localparam int OO = nd_level_off(GROUP, STAGES, i + 1);

    nd_tree_stage #(
      .IN_W (IW),
      .GROUP(GROUP),
      .LAST (i == STAGES - 1)
    ) u_stage (
      .clk_i       (sys_clk),
      .rst_ni      (resetl),
      .valid_i     (lvl_valid[i]),
      .ready_o     (lvl_ready[i]),
      .data_i      (lvl_data[IO +: IW]),
      .mode_i      (lvl_mode[i]),
      .all_masked_i(lvl_am[i]),
      .valid_o     (lvl_valid[i+1]),
      .ready_i     (lvl_ready[i+1]),
      .data_o      (lvl_data[OO +: OW]),
      .mode_o      (lvl_mode[i+1]),
      .all_masked_o(lvl_am[i+1])
    );
  end

  // Nothing is offered upstream while the pipe is held in reset
  assign in_ready   = lvl_ready[0] & resetl;
  assign out_valid  = lvl_valid[STAGES];
  assign q          = lvl_data[Q_OFF];
  assign all_masked = lvl_am[STAGES];

endmodule

// File: tb/tb_nd_tree_pipe.sv
// tb/tb_nd_tree_pipe.sv - directed and scoreboard bench for nd_tree_pipe
module tb_nd_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // main instance: WIDTH=7, GROUP=4
  logic       resetl, in_valid, in_ready, out_valid, out_ready, q, all_masked;
  logic [6:0] in_data, in_mask;
  logic [2:0] in_mode;

  nd_tree_pipe #(.WIDTH(7), .GROUP(4)) u_dut (
    .sys_clk   (clk),
    .resetl    (resetl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .all_masked(all_masked)
  );

  // sweep instances share one stimulus bus
  localparam int NCFG = 6;
  localparam int CFG_W [NCFG] = '{2, 7, 16, 33, 64, 64};
  localparam int CFG_G [NCFG] = '{2, 3, 4, 8, 2, 3};
  localparam int CFG_S [NCFG] = '{1, 2, 2, 2, 6, 4};

  logic            sw_resetl, sw_in_valid, sw_out_ready;
  logic [63:0]     sw_data, sw_mask;
  logic [2:0]      sw_mode;
  logic [NCFG-1:0] sw_in_ready, sw_out_valid, sw_q, sw_am;

  for (genvar k = 0; k < NCFG; k++) begin : g_sw
    nd_tree_pipe #(.WIDTH(CFG_W[k]), .GROUP(CFG_G[k])) u_sw (
      .sys_clk   (clk),
      .resetl    (sw_resetl),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_in_ready[k]),
      .in_data   (sw_data[CFG_W[k]-1:0]),
      .in_mask   (sw_mask[CFG_W[k]-1:0]),
      .in_mode   (sw_mode),
      .out_valid (sw_out_valid[k]),
      .out_ready (sw_out_ready),
      .q         (sw_q[k]),
      .all_masked(sw_am[k])
    );
  end

  // flat golden model: returns {all_masked, q}
  function automatic logic [1:0] model(input logic [63:0] d, input logic [63:0] m,
                                       input logic [2:0] mode, input int w);
    logic a, o, x, any, r;
    a = 1'b1; o = 1'b0; x = 1'b0; any = 1'b0;
    for (int i = 0; i < w; i++) begin
      if (m[i]) begin
        a   = a & d[i];
        o   = o | d[i];
        x   = x ^ d[i];
        any = 1'b1;
      end
    end
    case (mode)
      3'd1:    r = ~a;
      3'd2:    r = o;
      3'd3:    r = ~o;
      3'd4:    r = x;
      default: r = a;
    endcase
    return {~any, r};
  endfunction

  task automatic run_one(input logic [6:0] d, input logic [6:0] m, input logic [2:0] md,
                         output logic got_q, output logic got_am, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_mask = m; in_mode = md; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got_q  = q;
    got_am = all_masked;
  endtask

  task automatic test_reset;
    logic seen;
    resetl = 1'b0; in_valid = 1'b1; in_data = 7'h7F; in_mask = 7'h7F; in_mode = 3'd1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests_run++; if (q !== 1'b0) begin tests_failed++; $display("FAIL reset_q got %b exp 0", q); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    tests_run++; if (all_masked !== 1'b0) begin tests_failed++; $display("FAIL reset_all_masked got %b exp 0", all_masked); end
    @(negedge clk);
    resetl = 1'b1; in_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL reset_no_pulse got %b exp 0", seen); end
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after got %b exp 1", in_ready); end
  endtask

  task automatic test_nand_legacy;
    logic [6:0] dv [3] = '{7'h7F, 7'h7E, 7'h3F};
    logic       ev [3] = '{1'b0, 1'b1, 1'b1};
    logic gq, gam;
    int   lat;
    for (int i = 0; i < 3; i++) begin
      run_one(dv[i], 7'h7F, 3'd1, gq, gam, lat);
      tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL nand_latency[%0d] got %0d exp 2", i, lat); end
      tests_run++; if (gq !== ev[i]) begin tests_failed++; $display("FAIL nand_q[%0d] got %b exp %b", i, gq, ev[i]); end
    end
  endtask

  task automatic test_modes_b2b;
    logic [6:0] dv [5] = '{7'h7F, 7'h00, 7'h00, 7'h15, 7'h7F};
    logic [2:0] mv [5] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd0};
    logic       ev [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_early_valid got %b exp 0", out_valid); end
      end
      if (k >= 2) begin
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid[%0d] got %b exp 1", k - 2, out_valid); end
        tests_run++; if (q !== ev[k-2]) begin tests_failed++; $display("FAIL b2b_q[%0d] got %b exp %b", k - 2, q, ev[k-2]); end
      end
      if (k < 5) begin
        in_valid = 1'b1; in_data = dv[k]; in_mask = 7'h7F; in_mode = mv[k];
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", k, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_masking;
    logic [6:0] dv [5] = '{7'h00, 7'h7F, 7'h01, 7'h7E, 7'h7F};
    logic [6:0] mk [5] = '{7'h00, 7'h00, 7'h01, 7'h7F, 7'h7F};
    logic [2:0] mv [5] = '{3'd0, 3'd2, 3'd1, 3'd5, 3'd6};
    logic       eq [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ea [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic gq, gam;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      run_one(dv[i], mk[i], mv[i], gq, gam, lat);
      tests_run++; if (gq !== eq[i]) begin tests_failed++; $display("FAIL mask_q[%0d] got %b exp %b", i, gq, eq[i]); end
      tests_run++; if (gam !== ea[i]) begin tests_failed++; $display("FAIL mask_all_masked[%0d] got %b exp %b", i, gam, ea[i]); end
    end
  endtask

  task automatic test_backpressure;
    logic [1:0] exp_q [$];
    logic [1:0] want;
    logic [6:0] d, m;
    logic [2:0] md;
    logic       exp_ir;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    d = 7'($urandom); m = 7'($urandom); md = 3'($urandom_range(0, 7));
    while ((sent < 8 || got < 8) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 8) begin
        in_valid = 1'b1; in_data = d; in_mask = m; in_mode = md;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_ir = !(exp_q.size() == 2 && !out_ready);
      tests_run++; if (in_ready !== exp_ir) begin tests_failed++; $display("FAIL bp_in_ready cyc %0d got %b exp %b", cyc, in_ready, exp_ir); end
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL bp_duplicate got item exp none");
        end else begin
          want = exp_q.pop_front();
          if ({all_masked, q} !== want) begin tests_failed++; $display("FAIL bp_item[%0d] got %b exp %b", got, {all_masked, q}, want); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model({57'd0, d}, {57'd0, m}, md, 7));
        sent++;
        d = 7'($urandom); m = 7'($urandom); md = 3'($urandom_range(0, 7));
      end
    end
    tests_run++; if (cyc >= 300) begin tests_failed++; $display("FAIL bp_timeout got %0d cycles exp <300", cyc); end
    tests_run++; if (got !== 8) begin tests_failed++; $display("FAIL bp_count got %0d exp 8", got); end
    tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL bp_left got %0d exp 0", exp_q.size()); end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_sweep;
    logic [63:0] d, m;
    logic [2:0]  md;
    logic [1:0]  want;
    logic [1:0]  got [NCFG];
    int          lat [NCFG];
    logic [NCFG-1:0] seen;
    sw_out_ready = 1'b1; sw_in_valid = 1'b0;
    @(negedge clk);
    sw_resetl = 1'b1;
    for (int it = 0; it < 6; it++) begin
      d = {$urandom, $urandom}; m = {$urandom, $urandom}; md = 3'($urandom_range(0, 7));
      if (it == 0) m = '0;
      if (it == 1) begin d = '1; m = '1; md = 3'd1; end
      @(negedge clk);
      sw_in_valid = 1'b1; sw_data = d; sw_mask = m; sw_mode = md;
      #1;
      tests_run++; if (sw_in_ready !== {NCFG{1'b1}}) begin tests_failed++; $display("FAIL sweep_in_ready[%0d] got %b exp all 1", it, sw_in_ready); end
      for (int k = 0; k < NCFG; k++) begin lat[k] = 0; got[k] = 2'bxx; end
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (c == 1) sw_in_valid = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
          if (lat[k] == 0 && sw_out_valid[k]) begin lat[k] = c; got[k] = {sw_am[k], sw_q[k]}; end
        end
      end
      for (int k = 0; k < NCFG; k++) begin
        want = model(d, m, md, CFG_W[k]);
        tests_run++; if (lat[k] !== CFG_S[k]) begin tests_failed++; $display("FAIL sweep_lat W%0d G%0d got %0d exp %0d", CFG_W[k], CFG_G[k], lat[k], CFG_S[k]); end
        tests_run++; if (got[k] !== want) begin tests_failed++; $display("FAIL sweep_res W%0d G%0d it %0d got %b exp %b", CFG_W[k], CFG_G[k], it, got[k], want); end
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      sw_in_valid = 1'b1; sw_data = {$urandom, $urandom}; sw_mask = '1; sw_mode = 3'd4;
    end
    @(negedge clk);
    sw_in_valid = 1'b0; sw_resetl = 1'b0;
    #1;
    tests_run++; if (sw_out_valid !== '0) begin tests_failed++; $display("FAIL sweep_reset_valid got %b exp 0", sw_out_valid); end
    tests_run++; if (sw_in_ready !== '0) begin tests_failed++; $display("FAIL sweep_reset_ready got %b exp 0", sw_in_ready); end
    @(negedge clk);
    sw_resetl = 1'b1;
    seen = '0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | sw_out_valid;
    end
    tests_run++; if (seen !== '0) begin tests_failed++; $display("FAIL sweep_stale got %b exp 0", seen); end
  endtask

  initial begin
    sw_resetl = 1'b0; sw_in_valid = 1'b0; sw_out_ready = 1'b1;
    sw_data = '0; sw_mask = '0; sw_mode = 3'd0;
    test_reset();
    test_nand_legacy();
    test_modes_b2b();
    test_masking();
    test_backpressure();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
